acc_scheduler: RTL and testbench
================================

# acc_scheduler

Sequencer for the neuron-input `accumulator`. It owns the accumulator's `load`, `mode`, `src_addr`, `weight_in` and `time_step` pins. It programs synaptic weights from a host config port and buffers incoming spike addresses in a FIFO. It issues buffered spikes one per cycle, closes each time step after a fixed period, and latches the accumulated sum per step for the neuron stage.

## Interface
- `ADDR_W`, 10: source address width.
- `DATA_W`, 32: weight/sum width.
- `FIFO_DEPTH`, 16: spike FIFO entries, power of two.
- `STEP_CYCLES`, 50: RUN cycles per time step, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `enable` in 1: run time steps while high.
- `cfg_valid` in 1 / `cfg_ready` out 1: weight-write handshake.
- `cfg_addr` in ADDR_W / `cfg_weight` in DATA_W: weight write payload.
- `spike_valid` in 1 / `spike_ready` out 1: spike handshake.
- `spike_addr` in ADDR_W: source neuron address; 0 is the null address.
- `acc_load`, `acc_mode`, `acc_time_step` out 1: to the accumulator.
- `acc_src_addr` out ADDR_W / `acc_weight_in` out DATA_W: to the accumulator.
- `acc_out` in DATA_W: accumulator `accumulated_out`.
- `result` out DATA_W / `result_valid` out 1: per-step sum and one-cycle strobe.
- `step_count` out 16: completed steps.
- `fifo_full` out 1: spike FIFO status.

## Operation
- All accumulator-facing outputs are registered.
- **States:** IDLE, PROG_LOAD, PROG_GAP, RUN, FLUSH, STEP.
- **IDLE**
  - `cfg_ready`=1.
  - `cfg_valid`&`cfg_ready` captures the address/weight and moves to PROG_LOAD. Config has priority over `enable`.
  - Otherwise `enable` moves to RUN and clears the period counter.
- **PROG_LOAD:** `acc_mode`=1, `acc_load`=1, `acc_src_addr`/`acc_weight_in` = captured values. Lasts one cycle, then PROG_GAP.
- **PROG_GAP:** `acc_mode`=1, `acc_load`=0. Lasts one cycle, then IDLE. Maximum config rate is one write per 3 cycles.
- **RUN**
  - `acc_mode`=0, `cfg_ready`=0.
  - Each cycle with the FIFO non-empty: pop the head and drive it on `acc_src_addr`. When empty, drive 0.
  - The period counter increments each RUN cycle. At `STEP_CYCLES-1`, or when `enable` drops, go to FLUSH.
- **FLUSH**
  - `spike_ready`=0; popping continues one per cycle.
  - The FIFO becoming empty moves to STEP, in the cycle after the last issued address.
- **STEP**
  - `acc_time_step`=1 for one cycle, `acc_src_addr`=0.
  - `result` latches `acc_out`, the pre-clear sum.
  - `result_valid`=1 on the following cycle.
  - `step_count` increments, wrapping 0xFFFF→0.
  - Next state is RUN if `enable`, else IDLE.
- **Spike FIFO**
  - `spike_ready` = !full and state ∈ {IDLE, PROG_LOAD, PROG_GAP, RUN}.
  - Spikes accepted outside RUN are held until RUN.
  - Simultaneous push and pop leaves the count unchanged.
  - There is no bypass when full: a pop that frees a slot raises `spike_ready` next cycle.
- Address-0 spikes are accepted and issued as 0, which is a no-op in the accumulator.
- `acc_weight_in` = 0 outside PROG_LOAD.

## Timing
- **Reset values:** state IDLE, FIFO empty, all `acc_*` = 0, `result`=0, `result_valid`=0, `step_count`=0, `cfg_ready`=1. `spike_ready`=1 from the first post-reset cycle.
- **Reset mid-operation:** any state returns to IDLE and the FIFO is flushed without issue. No `acc_time_step` is generated.
- **Spike latency:** a spike accepted at cycle N in RUN with the FIFO empty appears on `acc_src_addr` at N+1.
- **Config latency:** `acc_load` is high in the cycle after acceptance.
- **Step period:** with no spikes in FLUSH, `acc_time_step` rises `STEP_CYCLES`+1 cycles after RUN entry.
- **Result latency:** `result_valid` is high 1 cycle after `acc_time_step`.

## Configuration
- **`ACC_SCHED_EXT_STEP_EN` defined:**
  - Adds input `step_req` (1 bit).
  - A high `step_req` in RUN forces FLUSH that cycle, regardless of the period counter.
  - `step_req` is ignored in other states.
- **Undefined:** no port; steps end only on the period counter or `enable` falling.

## Test plan
- **Programming:** reset, then write (1,1),(2,2),(3,3),(4,4).
  - Expect four `acc_load` pulses, 3 cycles apart, each with `acc_mode`=1.
  - Expect `cfg_ready` low during PROG states.
- **Step 1:** assert `enable`, push spikes 1,2,3,2.
  - Addresses issue 1/cycle in order.
  - At step end `result`=8, `result_valid` pulses once, `step_count`=1.
- **Step 2:** push 1,2,3.
  - `result`=6, `step_count`=2.
  - The empty step that follows gives `result`=0.
- **Backpressure:** in IDLE push 20 spikes with `FIFO_DEPTH`=16.
  - `fifo_full`=1 and `spike_ready`=0 after 16 accepts.
  - On `enable`, all 16 issue in order before the first `acc_time_step`.
- **Boundary:** drop `enable` mid-RUN with 5 queued.
  - Expect 5 issues, one `acc_time_step`, then IDLE.
  - Reset asserted in FLUSH yields IDLE, empty FIFO and no `acc_time_step`.
- **Macro:** with `ACC_SCHED_EXT_STEP_EN`, pulse `step_req` 10 cycles into RUN with 1 queued spike.
  - `acc_time_step` is asserted 2 cycles later.
  - Without the macro, the step waits the full period.

Source files
------------

// File: rtl/acc_scheduler.sv
// acc_scheduler: programs accumulator weights, buffers spikes and sequences time steps.
// Build option: define ACC_SCHED_EXT_STEP_EN to add a step_req input that ends a RUN period early.
module acc_scheduler #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int STEP_CYCLES = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
`ifdef ACC_SCHED_EXT_STEP_EN
  input  logic              step_req,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_weight,
  input  logic              spike_valid,
  output logic              spike_ready,
  input  logic [ADDR_W-1:0] spike_addr,
  output logic              acc_load,
  output logic              acc_mode,
  output logic              acc_time_step,
  output logic [ADDR_W-1:0] acc_src_addr,
  output logic [DATA_W-1:0] acc_weight_in,
  input  logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [15:0]       step_count,
  output logic              fifo_full
);

  // state     | meaning
  // IDLE      | wait for a weight write or enable
  // PROG_LOAD | drive one weight write into the accumulator
  // PROG_GAP  | one settle cycle before the next write
  // RUN       | issue buffered spikes, count the step period
  // FLUSH     | drain the FIFO without accepting new spikes
  // STEP      | close the time step and latch the sum
  typedef enum logic [2:0] {
    S_IDLE, S_PROG_LOAD, S_PROG_GAP, S_RUN, S_FLUSH, S_STEP
  } state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(STEP_CYCLES);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [TMR_W-1:0]    r_tmr;
  logic                r_acc_load;
  logic                r_acc_mode;
  logic                r_acc_time_step;
  logic [ADDR_W-1:0]   r_acc_src_addr;
  logic [DATA_W-1:0]   r_acc_weight_in;
  logic [DATA_W-1:0]   r_result;
  logic                r_result_valid;
  logic [15:0]         r_step_count;

  logic                w_full;
  logic                w_empty;
  logic                w_spike_ready;
  logic                w_push;
  logic                w_write;
  logic                w_pop;
  logic                w_bypass;
  logic                w_tmr_load;
  logic                w_cfg_take;
  logic                w_step_req;
  logic [ADDR_W-1:0]   w_head;
  logic [ADDR_W-1:0]   w_issue;

`ifdef ACC_SCHED_EXT_STEP_EN
  assign w_step_req = step_req;
`else
  assign w_step_req = 1'b0;
`endif

  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_spike_ready = !w_full && (r_state inside {S_IDLE, S_PROG_LOAD, S_PROG_GAP, S_RUN});
  assign w_push        = spike_valid && w_spike_ready;
  assign w_write       = w_push && !w_bypass;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_bypass    = 1'b0;
    w_tmr_load  = 1'b0;
    w_cfg_take  = 1'b0;
    w_issue     = '0;
    case (r_state)
      S_IDLE: begin
        if (cfg_valid) begin
          w_cfg_take  = 1'b1;
          w_state_nxt = S_PROG_LOAD;
        end else if (enable) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_PROG_LOAD: w_state_nxt = S_PROG_GAP;
      S_PROG_GAP:  w_state_nxt = S_IDLE;
      S_RUN: begin
        // an empty FIFO forwards the incoming spike straight to the issue register
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_issue = w_head;
        end else if (w_push) begin
          w_bypass = 1'b1;
          w_issue  = spike_addr;
        end
        if (r_tmr == '0 || !enable || w_step_req) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_issue = w_head;
        end else begin
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (enable) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= spike_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_tmr           <= '0;
      r_acc_load      <= 1'b0;
      r_acc_mode      <= 1'b0;
      r_acc_time_step <= 1'b0;
      r_acc_src_addr  <= '0;
      r_acc_weight_in <= '0;
      r_result        <= '0;
      r_result_valid  <= 1'b0;
      r_step_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_tmr_load) r_tmr <= TMR_W'(STEP_CYCLES - 1);
      else if (r_state == S_RUN && r_tmr != '0) r_tmr <= r_tmr - TMR_W'(1);
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_acc_load      <= w_cfg_take;
      r_acc_mode      <= (w_state_nxt == S_PROG_LOAD) || (w_state_nxt == S_PROG_GAP);
      r_acc_time_step <= (w_state_nxt == S_STEP);
      r_acc_src_addr  <= w_cfg_take ? cfg_addr : w_issue;
      r_acc_weight_in <= w_cfg_take ? cfg_weight : '0;
      r_result_valid  <= (r_state == S_STEP);
      if (r_state == S_STEP) begin
        r_result     <= acc_out;
        r_step_count <= r_step_count + 16'd1;
      end
    end
  end

  assign cfg_ready     = (r_state == S_IDLE);
  assign spike_ready   = w_spike_ready;
  assign fifo_full     = w_full;
  assign acc_load      = r_acc_load;
  assign acc_mode      = r_acc_mode;
  assign acc_time_step = r_acc_time_step;
  assign acc_src_addr  = r_acc_src_addr;
  assign acc_weight_in = r_acc_weight_in;
  assign result        = r_result;
  assign result_valid  = r_result_valid;
  assign step_count    = r_step_count;

endmodule

// File: tb/tb_acc_scheduler.sv
// Testbench for acc_scheduler: queue-level reference model plus a simple accumulator stand-in.
module tb_acc_scheduler;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int SC = 50;

  logic clk, rst, enable, cfg_valid, spike_valid;
  logic [AW-1:0] cfg_addr, spike_addr;
  logic [DW-1:0] cfg_weight, acc_out;
  logic cfg_ready, spike_ready, acc_load, acc_mode, acc_time_step, result_valid, fifo_full;
  logic [AW-1:0] acc_src_addr;
  logic [DW-1:0] acc_weight_in, result;
  logic [15:0] step_count;
`ifdef ACC_SCHED_EXT_STEP_EN
  logic step_req;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  acc_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef ACC_SCHED_EXT_STEP_EN
    .step_req(step_req),
`endif
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_addr(spike_addr),
    .acc_load(acc_load), .acc_mode(acc_mode), .acc_time_step(acc_time_step),
    .acc_src_addr(acc_src_addr), .acc_weight_in(acc_weight_in), .acc_out(acc_out),
    .result(result), .result_valid(result_valid), .step_count(step_count), .fifo_full(fifo_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 60) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting, got no event expected one", nm);
  endtask

  // accumulator stand-in: weight memory and running sum
  logic [DW-1:0] env_wmem [1024];
  logic [DW-1:0] env_sum;
  assign acc_out = env_sum;
  initial begin
    for (int i = 0; i < 1024; i++) env_wmem[i] = '0;
    forever begin
      @(posedge clk);
      if (!rst) env_sum <= '0;
      else if (acc_time_step) env_sum <= '0;
      else if (acc_mode) begin
        if (acc_load) env_wmem[acc_src_addr] = acc_weight_in;
      end else if (acc_src_addr != '0) env_sum <= env_sum + env_wmem[acc_src_addr];
    end
  end

  // reference model: a spike queue plus the step bookkeeping
  typedef enum int {MP_IDLE, MP_LOAD, MP_GAP, MP_RUN, MP_FLUSH, MP_STEP} mphase_t;
  mphase_t m_phase = MP_IDLE;
  logic [AW-1:0] m_q[$];
  logic [DW-1:0] m_wt [1024];
  int m_elapsed;
  logic [DW-1:0] m_step_sum;
  bit m_live = 1'b0;
  logic e_load, e_mode, e_ts, e_rv;
  logic [AW-1:0] e_src;
  logic [DW-1:0] e_win, e_result;
  logic [15:0] e_steps;

  function automatic bit m_sready();
    return (m_q.size() < DEPTH) && (m_phase inside {MP_IDLE, MP_LOAD, MP_GAP, MP_RUN});
  endfunction

  initial begin
    bit acc;
    bit end_run;
    logic [AW-1:0] a;
    mphase_t np;
    for (int i = 0; i < 1024; i++) m_wt[i] = '0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_phase = MP_IDLE; m_q.delete(); m_elapsed = 0; m_step_sum = '0;
        e_load = 0; e_mode = 0; e_ts = 0; e_rv = 0; e_src = '0; e_win = '0;
        e_result = '0; e_steps = '0; m_live = 1'b1;
      end else begin
        acc = spike_valid && m_sready();
        np = m_phase;
        e_load = 0; e_mode = 0; e_ts = 0; e_rv = 0; e_src = '0; e_win = '0;
        if (acc) m_q.push_back(spike_addr);
        case (m_phase)
          MP_IDLE: begin
            if (cfg_valid) begin
              np = MP_LOAD; e_load = 1; e_mode = 1; e_src = cfg_addr; e_win = cfg_weight;
              m_wt[cfg_addr] = cfg_weight;
            end else if (enable) begin
              np = MP_RUN; m_elapsed = 0;
            end
          end
          MP_LOAD: begin np = MP_GAP; e_mode = 1; end
          MP_GAP: np = MP_IDLE;
          MP_RUN: begin
            if (m_q.size() > 0) begin
              a = m_q.pop_front(); e_src = a;
              if (a != '0) m_step_sum = m_step_sum + m_wt[a];
            end
            end_run = (m_elapsed == SC - 1) || !enable;
`ifdef ACC_SCHED_EXT_STEP_EN
            end_run = end_run || step_req;
`endif
            if (end_run) np = MP_FLUSH;
            else m_elapsed++;
          end
          MP_FLUSH: begin
            if (m_q.size() > 0) begin
              a = m_q.pop_front(); e_src = a;
              if (a != '0) m_step_sum = m_step_sum + m_wt[a];
            end else begin
              np = MP_STEP; e_ts = 1;
            end
          end
          default: begin
            e_result = m_step_sum; m_step_sum = '0; e_rv = 1; e_steps = e_steps + 16'd1;
            if (enable) begin np = MP_RUN; m_elapsed = 0; end
            else np = MP_IDLE;
          end
        endcase
        m_phase = np;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("acc_load", acc_load, e_load);
        chk("acc_mode", acc_mode, e_mode);
        chk("acc_time_step", acc_time_step, e_ts);
        chk("acc_src_addr", acc_src_addr, e_src);
        chk("acc_weight_in", acc_weight_in, e_win);
        chk("result", result, e_result);
        chk("result_valid", result_valid, e_rv);
        chk("step_count", step_count, e_steps);
        chk("cfg_ready", cfg_ready, m_phase == MP_IDLE);
        chk("spike_ready", spike_ready, m_sready());
        chk("fifo_full", fifo_full, m_q.size() == DEPTH);
      end
    end
  end

  // event logs for the directed literal checks
  int cyc = 0;
  int ts_cnt = 0;
  int ld_cyc[$];
  logic [AW-1:0] iss_q[$];
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (acc_load === 1'b1) ld_cyc.push_back(cyc);
      if (acc_mode === 1'b0 && acc_src_addr != '0) iss_q.push_back(acc_src_addr);
      if (acc_time_step === 1'b1) ts_cnt++;
    end
  end

  task automatic wait_rv(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (result_valid !== 1'b1 && k < 300);
    if (result_valid !== 1'b1) timeout(nm);
  endtask

  task automatic chk_list(input string nm, input logic [AW-1:0] expq[$]);
    chk({nm, "_len"}, iss_q.size(), expq.size());
    for (int i = 0; i < expq.size() && i < iss_q.size(); i++) chk(nm, iss_q[i], expq[i]);
  endtask

  task automatic push_list(input logic [AW-1:0] pat[$]);
    for (int i = 0; i < pat.size(); i++) begin
      spike_valid = 1'b1;
      spike_addr = pat[i];
      @(negedge clk);
    end
    spike_valid = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] pat[$];
    int k;
    rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0; spike_valid = 1'b0;
    cfg_addr = '0; cfg_weight = '0; spike_addr = '0;
`ifdef ACC_SCHED_EXT_STEP_EN
    step_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_spike_ready", spike_ready, 1);
    chk("rst_step_count", step_count, 0);
    chk("rst_result", result, 0);

    for (int i = 1; i <= 4; i++) begin
      cfg_valid = 1'b1; cfg_addr = AW'(i); cfg_weight = DW'(i);
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    chk("prog_loads", ld_cyc.size(), 4);
    for (int i = 1; i < ld_cyc.size(); i++) chk("prog_spacing", ld_cyc[i] - ld_cyc[i-1], 3);

    enable = 1'b1;
    @(negedge clk);
    iss_q.delete();
    pat = '{10'd1, 10'd2, 10'd3, 10'd2};
    push_list(pat);
    wait_rv("step1_rv");
    chk("step1_result", result, 8);
    chk("step1_count", step_count, 1);
    chk_list("step1_order", pat);
    iss_q.delete();
    pat = '{10'd1, 10'd2, 10'd3};
    push_list(pat);
    wait_rv("step2_rv");
    chk("step2_result", result, 6);
    chk("step2_count", step_count, 2);
    chk_list("step2_order", pat);
    wait_rv("step3_rv");
    chk("empty_step_result", result, 0);
    chk("step3_count", step_count, 3);
    enable = 1'b0;
    wait_rv("step4_rv");
    repeat (2) @(negedge clk);
    chk("back_to_idle", cfg_ready, 1);

    iss_q.delete();
    pat.delete();
    for (int i = 1; i <= 20; i++) pat.push_back(AW'(i));
    push_list(pat);
    chk("bp_fifo_full", fifo_full, 1);
    chk("bp_spike_ready", spike_ready, 0);
    enable = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (acc_time_step !== 1'b1 && k < 300);
    if (acc_time_step !== 1'b1) timeout("bp_time_step");
    enable = 1'b0;
    pat.delete();
    for (int i = 1; i <= 16; i++) pat.push_back(AW'(i));
    chk_list("bp_order", pat);
    wait_rv("bp_rv");
    chk("bp_result", result, 10);

    @(negedge clk);
    pat = '{10'd4, 10'd3, 10'd2, 10'd1, 10'd4};
    push_list(pat);
    iss_q.delete();
    ts_cnt = 0;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_rv("drop_rv");
    chk("drop_result", result, 14);
    chk("drop_ts_pulses", ts_cnt, 1);
    chk_list("drop_order", pat);
    chk("drop_count", step_count, 6);
    repeat (2) @(negedge clk);
    chk("drop_idle", cfg_ready, 1);

    pat.delete();
    for (int i = 0; i < 10; i++) pat.push_back(10'd1);
    push_list(pat);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("in_flush_before_reset", fifo_full, 0);
    ts_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_flush_no_ts", ts_cnt, 0);
    chk("rst_flush_idle", cfg_ready, 1);
    chk("rst_flush_ready", spike_ready, 1);
    chk("rst_flush_src", acc_src_addr, 0);
    chk("rst_flush_count", step_count, 0);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) enable = !enable;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_addr = AW'($urandom_range(1, 7));
      cfg_weight = DW'($urandom_range(0, 1000));
      spike_valid = ($urandom_range(0, 1) == 1);
      spike_addr = AW'($urandom_range(0, 7));
`ifdef ACC_SCHED_EXT_STEP_EN
      step_req = ($urandom_range(0, 29) == 0);
`endif
      @(negedge clk);
    end
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; spike_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
